// File: rtl/sobel_pkg.sv
// Shared types and width helpers for the streaming Sobel edge pipeline.
// Gradient and magnitude widths derive from the luma width.
package sobel_pkg;

    typedef enum logic [1:0] {
        MAG     = 2'd0,
        BIN     = 2'd1,
        BIN_INV = 2'd2,
        BYPASS  = 2'd3
    } sobel_mode_e;

    function automatic int grad_w(input int pix_w);
        return pix_w + 3;
    endfunction

    function automatic int mag_w(input int pix_w);
        return pix_w + 4;
    endfunction

endpackage

// File: rtl/sobel_edge_pipe_if.sv
// Pixel-in / result-out valid-ready streams of the Sobel pipeline.
// master = stream source and sink side, slave = the pipeline.
interface sobel_edge_pipe_if #(
    parameter int PIX_W  = 8,
    parameter int OUT_CH = 3
);
    logic [PIX_W-1:0]        input_fifo_data_yuv;
    logic                    input_fifo_valid_yuv;
    logic                    input_fifo_ready_yuv;
    logic                    output_fifo_ready;
    logic                    output_fifo_valid;
    logic [OUT_CH*PIX_W-1:0] output_fifo_data_yuv;

    modport master (
        output input_fifo_data_yuv,
        output input_fifo_valid_yuv,
        input  input_fifo_ready_yuv,
        output output_fifo_ready,
        input  output_fifo_valid,
        input  output_fifo_data_yuv
    );

    modport slave (
        input  input_fifo_data_yuv,
        input  input_fifo_valid_yuv,
        output input_fifo_ready_yuv,
        input  output_fifo_ready,
        output output_fifo_valid,
        output output_fifo_data_yuv
    );
endinterface

// File: rtl/sobel_line_buf.sv
// One line of luma history: async read of the old word, write on enable.
// Contents are deliberately not reset; two rows rebuild them each frame.
module sobel_line_buf #(
    parameter int DEPTH = 1920,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (en_i) mem_q[addr_i] <= wdata_i;
    end
endmodule

// File: rtl/sobel_edge_pipe.sv
// Streaming 3x3 Sobel: two line buffers, window, Gx/Gy, |Gx|+|Gy| output.
// One global enable stalls the whole pipe under output backpressure.
module sobel_edge_pipe
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 1920,
    parameter int IMG_H  = 1080,
    parameter int PIX_W  = 8,
    parameter int OUT_CH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    sobel_edge_pipe_if.slave  io,
    input  logic [1:0]        cfg_mode,
    input  logic [PIX_W-1:0]  cfg_threshold,
    output logic              frame_done
);
    localparam int GW = grad_w(PIX_W);
    localparam int MW = mag_w(PIX_W);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [PIX_W-1:0] PMAX = '1;

    logic adv, acc, col_end, last_px, first_px, win_ok;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    sobel_mode_e mode_q, mode_d, mode_px, m0_q, m1_q;
    logic [PIX_W-1:0] thr_q, thr_d, thr_px, t0_q, t1_q;
    logic [PIX_W-1:0] lb1_rd, lb2_rd, c1_q;
    logic [PIX_W-1:0] win_q [3][3];
    logic v0_q, l0_q, v1_q, l1_q;
    logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
    logic [GW-1:0] ax, ay;
    logic [MW-1:0] mag_d;
    logic hit;
    logic [PIX_W-1:0] sat, res_d;
    logic out_valid_q, out_last_q;
    logic [OUT_CH*PIX_W-1:0] out_data_q;

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({{(GW-PIX_W){1'b0}}, p});
    endfunction

    assign adv = !out_valid_q || io.output_fifo_ready;
    assign acc = io.input_fifo_valid_yuv && adv;
    assign io.input_fifo_ready_yuv  = adv;
    assign io.output_fifo_valid     = out_valid_q;
    assign io.output_fifo_data_yuv  = out_data_q;
    assign frame_done = out_valid_q && out_last_q && io.output_fifo_ready;

    assign col_end  = col_q == CW'(IMG_W - 1);
    assign last_px  = col_end && row_q == RW'(IMG_H - 1);
    assign first_px = col_q == '0 && row_q == '0;
    assign win_ok   = row_q >= RW'(2) && col_q >= CW'(2);
    // Config rides with each pixel so the tail of the old frame keeps its mode.
    assign mode_px  = first_px ? sobel_mode_e'(cfg_mode) : mode_q;
    assign thr_px   = first_px ? cfg_threshold : thr_q;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        mode_d = acc ? mode_px : mode_q;
        thr_d  = acc ? thr_px : thr_q;
        if (acc) begin
            if (col_end) begin
                col_d = '0;
                row_d = last_px ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk(clk), .en_i(acc), .addr_i(col_q),
        .wdata_i(io.input_fifo_data_yuv), .rdata_o(lb1_rd)
    );

    sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk(clk), .en_i(acc), .addr_i(col_q),
        .wdata_i(lb1_rd), .rdata_o(lb2_rd)
    );

    assign gx_d = ext(win_q[0][2]) + ext(win_q[1][2]) + ext(win_q[1][2])
                + ext(win_q[2][2]) - ext(win_q[0][0]) - ext(win_q[1][0])
                - ext(win_q[1][0]) - ext(win_q[2][0]);
    assign gy_d = ext(win_q[2][0]) + ext(win_q[2][1]) + ext(win_q[2][1])
                + ext(win_q[2][2]) - ext(win_q[0][0]) - ext(win_q[0][1])
                - ext(win_q[0][1]) - ext(win_q[0][2]);

    always_comb begin
        ax    = gx_q[GW-1] ? -gx_q : gx_q;
        ay    = gy_q[GW-1] ? -gy_q : gy_q;
        mag_d = MW'(ax) + MW'(ay);
        sat   = (mag_d > MW'(PMAX)) ? PMAX : mag_d[PIX_W-1:0];
        hit   = mag_d >= MW'(t1_q);
        res_d = '0;
        unique case (1'b1)
            (m1_q == MAG):     res_d = sat;
            (m1_q == BIN):     res_d = hit ? PMAX : '0;
            (m1_q == BIN_INV): res_d = hit ? '0 : PMAX;
            (m1_q == BYPASS):  res_d = c1_q;
            default:           res_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb2_rd;
            win_q[1][2] <= lb1_rd;
            win_q[2][2] <= io.input_fifo_data_yuv;
            m0_q <= mode_px;
            t0_q <= thr_px;
        end
        if (adv) begin
            gx_q <= gx_d;
            gy_q <= gy_d;
            c1_q <= win_q[1][1];
            m1_q <= m0_q;
            t1_q <= t0_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= MAG;
            thr_q       <= '0;
            v0_q        <= 1'b0;
            l0_q        <= 1'b0;
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            mode_q <= mode_d;
            thr_q  <= thr_d;
            if (adv) begin
                v0_q        <= acc && win_ok;
                l0_q        <= acc && last_px;
                v1_q        <= v0_q;
                l1_q        <= l0_q;
                out_valid_q <= v1_q;
                out_last_q  <= l1_q;
                if (v1_q) out_data_q <= {OUT_CH{res_d}};
            end
        end
    end
endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Bench for sobel_edge_pipe: 8x6 and 16x12 instances checked against
// an array-based Sobel model of whole frames.
module tb_sobel_edge_pipe;
    localparam int AW = 8, AH = 6, BW = 16, BH = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sobel_edge_pipe_if #(.PIX_W(8), .OUT_CH(3)) ifa ();
    sobel_edge_pipe_if #(.PIX_W(8), .OUT_CH(3)) ifb ();
    logic [1:0] mode_a, mode_b;
    logic [7:0] thr_a, thr_b;
    logic       fd_a, fd_b;

    sobel_edge_pipe #(.IMG_W(AW), .IMG_H(AH), .PIX_W(8), .OUT_CH(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .io(ifa),
        .cfg_mode(mode_a), .cfg_threshold(thr_a), .frame_done(fd_a)
    );
    sobel_edge_pipe #(.IMG_W(BW), .IMG_H(BH), .PIX_W(8), .OUT_CH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .io(ifb),
        .cfg_mode(mode_b), .cfg_threshold(thr_b), .frame_done(fd_b)
    );

    int n_checks = 0, n_fail = 0, cyc = 0;
    int pix [0:191];
    int cw;
    logic [23:0] exp_q[$], got_a[$], got_b[$];
    int fdc_a = 0, fdc_b = 0, acc_a = 0;
    int first_acc = -1, first_out = -1;
    int stall_err = 0, stall_seen = 0;
    bit rnd_rdy = 0;
    logic pv = 0, pr = 0;
    logic [23:0] pd = '0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        ifb.output_fifo_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (ifa.input_fifo_valid_yuv && ifa.input_fifo_ready_yuv) begin
            if (acc_a == 2 * AW + 2 && first_acc < 0) first_acc = cyc;
            acc_a++;
        end
        if (ifa.output_fifo_valid && first_out < 0) first_out = cyc;
        if (ifa.output_fifo_valid && ifa.output_fifo_ready)
            got_a.push_back(ifa.output_fifo_data_yuv);
        if (fd_a) fdc_a++;
    end

    always @(negedge clk) begin
        if (rst_n && pv && !pr) begin
            stall_seen++;
            if (!ifb.output_fifo_valid || ifb.output_fifo_data_yuv !== pd)
                stall_err++;
        end
        if (ifb.output_fifo_valid && !ifb.output_fifo_ready && ifb.input_fifo_ready_yuv)
            stall_err++;
        pv = ifb.output_fifo_valid;
        pr = ifb.output_fifo_ready;
        pd = ifb.output_fifo_data_yuv;
        if (ifb.output_fifo_valid && ifb.output_fifo_ready)
            got_b.push_back(ifb.output_fifo_data_yuv);
        if (fd_b) fdc_b++;
    end

    function automatic int px(input int r, input int c);
        return pix[r * cw + c];
    endfunction

    // Appends the expected interior words of the frame held in pix.
    function automatic void model(input int W, input int H, input int mode, input int thr);
        int gx, gy, mag;
        logic [7:0] v;
        cw = W;
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++) begin
                gx = px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1)
                   - px(r-1, c-1) - 2 * px(r, c-1) - px(r+1, c-1);
                gy = px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1)
                   - px(r-1, c-1) - 2 * px(r-1, c) - px(r-1, c+1);
                mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                case (mode)
                    0: v = (mag > 255) ? 8'hFF : 8'(mag);
                    1: v = (mag >= thr) ? 8'hFF : 8'h00;
                    2: v = (mag >= thr) ? 8'h00 : 8'hFF;
                    default: v = 8'(px(r, c));
                endcase
                exp_q.push_back({v, v, v});
            end
    endfunction

    task automatic drive(input bit b, input bit v, input logic [7:0] d);
        if (b) begin
            ifb.input_fifo_valid_yuv = v;
            ifb.input_fifo_data_yuv  = d;
        end else begin
            ifa.input_fifo_valid_yuv = v;
            ifa.input_fifo_data_yuv  = d;
        end
    endtask

    task automatic set_cfg(input bit b, input logic [1:0] m, input logic [7:0] t);
        if (b) begin mode_b = m; thr_b = t; end
        else   begin mode_a = m; thr_a = t; end
    endtask

    task automatic send_frame(input bit b, input int n, input int gap, input bit scramble);
        int k;
        for (int i = 0; i < n; i++) begin
            while (gap > 0 && $urandom_range(0, 99) < gap) begin
                drive(b, 1'b0, 8'h00);
                @(posedge clk); #1;
            end
            drive(b, 1'b1, 8'(pix[i]));
            k = 0;
            forever begin
                @(negedge clk);
                if (b ? ifb.input_fifo_ready_yuv : ifa.input_fifo_ready_yuv) break;
                if (++k > 2000) begin
                    n_checks++; n_fail++;
                    $display("FAIL input_accept pixel %0d: ready stuck low, required high", i);
                    drive(b, 1'b0, 8'h00);
                    return;
                end
            end
            @(posedge clk); #1;
            if (scramble && i == 0) set_cfg(b, 2'd3, 8'hFF);
        end
        drive(b, 1'b0, 8'h00);
    endtask

    task automatic wait_words(input bit b, input int n);
        int k = 0;
        while ((b ? got_b.size() : got_a.size()) < n && k < 3000) begin
            @(posedge clk); k++;
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks += 4;
        if (ifa.output_fifo_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid: got %b required 0", ifa.output_fifo_valid); end
        if (ifa.output_fifo_data_yuv !== 24'h0) begin n_fail++;
            $display("FAIL reset_data: got %h required 000000", ifa.output_fifo_data_yuv); end
        if (fd_a !== 1'b0) begin n_fail++;
            $display("FAIL reset_frame_done: got %b required 0", fd_a); end
        if (ifa.input_fifo_ready_yuv !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready: got %b required 1", ifa.input_fifo_ready_yuv); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_flat();
        for (int i = 0; i < AW * AH; i++) pix[i] = 100;
        exp_q.delete(); got_a.delete(); fdc_a = 0;
        model(AW, AH, 0, 0);
        set_cfg(0, 2'd0, 8'd0);
        send_frame(0, AW * AH, 0, 0);
        wait_words(0, 24);
        n_checks += 2;
        if (got_a.size() !== 24) begin n_fail++;
            $display("FAIL flat_count: got %0d required 24", got_a.size()); end
        if (fdc_a !== 1) begin n_fail++;
            $display("FAIL flat_frame_done: got %0d required 1", fdc_a); end
        for (int i = 0; i < got_a.size() && i < 24; i++) begin
            n_checks++;
            if (got_a[i] !== 24'h0) begin n_fail++;
                $display("FAIL flat_word %0d: got %h required 000000", i, got_a[i]); end
        end
    endtask

    task automatic test_step();
        int nsat = 0;
        for (int i = 0; i < AW * AH; i++) pix[i] = (i % AW < 4) ? 0 : 255;
        exp_q.delete(); got_a.delete(); fdc_a = 0;
        model(AW, AH, 0, 0);
        set_cfg(0, 2'd0, 8'd0);
        send_frame(0, AW * AH, 20, 0);
        wait_words(0, 24);
        n_checks++;
        if (got_a.size() !== exp_q.size()) begin n_fail++;
            $display("FAIL step_count: got %0d required %0d", got_a.size(), exp_q.size()); end
        for (int i = 0; i < got_a.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_a[i] == 24'hFFFFFF) nsat++;
            if (got_a[i] !== exp_q[i]) begin n_fail++;
                $display("FAIL step_word %0d: got %h required %h", i, got_a[i], exp_q[i]); end
        end
        n_checks++;
        if (nsat !== 8) begin n_fail++;
            $display("FAIL step_saturated: got %0d words required 8", nsat); end
    endtask

    task automatic test_binary();
        for (int i = 0; i < AW * AH; i++) pix[i] = (i % AW < 4) ? 0 : 255;
        exp_q.delete(); got_a.delete(); fdc_a = 0;
        model(AW, AH, 1, 200);
        model(AW, AH, 2, 255);
        set_cfg(0, 2'd1, 8'd200);
        send_frame(0, AW * AH, 0, 1);
        set_cfg(0, 2'd2, 8'd255);
        send_frame(0, AW * AH, 0, 1);
        wait_words(0, 48);
        n_checks += 2;
        if (got_a.size() !== 48) begin n_fail++;
            $display("FAIL binary_count: got %0d required 48", got_a.size()); end
        if (fdc_a !== 2) begin n_fail++;
            $display("FAIL binary_frame_done: got %0d required 2", fdc_a); end
        for (int i = 0; i < got_a.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_a[i] !== exp_q[i]) begin n_fail++;
                $display("FAIL binary_word %0d: got %h required %h", i, got_a[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_stall();
        rnd_rdy = 1; stall_err = 0; stall_seen = 0;
        for (int f = 0; f < 2; f++) begin
            int m = (f == 0) ? 0 : $urandom_range(0, 3);
            int t = $urandom_range(0, 255);
            for (int r = 0; r < BH; r++)
                for (int c = 0; c < BW; c++)
                    pix[r * BW + c] = (f == 0) ? ((r * 13 + c * 9) & 255) : $urandom_range(0, 255);
            exp_q.delete(); got_b.delete(); fdc_b = 0;
            model(BW, BH, m, t);
            set_cfg(1, 2'(m), 8'(t));
            send_frame(1, BW * BH, 50, 0);
            wait_words(1, 140);
            n_checks += 2;
            if (got_b.size() !== 140) begin n_fail++;
                $display("FAIL random_count f%0d: got %0d required 140", f, got_b.size()); end
            if (fdc_b !== 1) begin n_fail++;
                $display("FAIL random_frame_done f%0d: got %0d required 1", f, fdc_b); end
            for (int i = 0; i < got_b.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (got_b[i] !== exp_q[i]) begin n_fail++;
                    $display("FAIL random_word f%0d/%0d: got %h required %h", f, i, got_b[i], exp_q[i]); end
            end
        end
        rnd_rdy = 0;
        n_checks++;
        if (stall_err !== 0) begin n_fail++;
            $display("FAIL stall_stable: got %0d violations over %0d stalls required 0", stall_err, stall_seen); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < AW * AH; i++) pix[i] = $urandom_range(0, 255);
        exp_q.delete(); got_a.delete(); fdc_a = 0;
        acc_a = 0; first_acc = -1; first_out = -1;
        model(AW, AH, 0, 0);
        model(AW, AH, 0, 0);
        set_cfg(0, 2'd0, 8'd0);
        send_frame(0, AW * AH, 0, 0);
        send_frame(0, AW * AH, 0, 0);
        wait_words(0, 48);
        n_checks += 3;
        if (got_a.size() !== 48) begin n_fail++;
            $display("FAIL b2b_count: got %0d required 48", got_a.size()); end
        if (fdc_a !== 2) begin n_fail++;
            $display("FAIL b2b_frame_done: got %0d required 2", fdc_a); end
        if (first_out - first_acc !== 3) begin n_fail++;
            $display("FAIL b2b_latency: got %0d cycles required 3", first_out - first_acc); end
        for (int i = 0; i < got_a.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_a[i] !== exp_q[i]) begin n_fail++;
                $display("FAIL b2b_word %0d: got %h required %h", i, got_a[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < AW * AH; i++) pix[i] = $urandom_range(0, 255);
        set_cfg(0, 2'd0, 8'd0);
        send_frame(0, 20, 0, 0);
        @(posedge clk); #1;
        n_checks++;
        if (ifa.output_fifo_valid !== 1'b1) begin n_fail++;
            $display("FAIL midframe_valid_before: got %b required 1", ifa.output_fifo_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (ifa.output_fifo_valid !== 1'b0) begin n_fail++;
            $display("FAIL midframe_async_valid: got %b required 0", ifa.output_fifo_valid); end
        if (ifa.output_fifo_data_yuv !== 24'h0) begin n_fail++;
            $display("FAIL midframe_async_data: got %h required 000000", ifa.output_fifo_data_yuv); end
        if (ifa.input_fifo_ready_yuv !== 1'b1) begin n_fail++;
            $display("FAIL midframe_ready: got %b required 1", ifa.input_fifo_ready_yuv); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < AW * AH; i++) pix[i] = $urandom_range(0, 255);
        exp_q.delete(); got_a.delete(); fdc_a = 0;
        model(AW, AH, 1, 300 - 200);
        set_cfg(0, 2'd1, 8'd100);
        send_frame(0, AW * AH, 0, 0);
        wait_words(0, 24);
        n_checks += 2;
        if (got_a.size() !== 24) begin n_fail++;
            $display("FAIL midframe_count: got %0d required 24", got_a.size()); end
        if (fdc_a !== 1) begin n_fail++;
            $display("FAIL midframe_frame_done: got %0d required 1", fdc_a); end
        for (int i = 0; i < got_a.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_a[i] !== exp_q[i]) begin n_fail++;
                $display("FAIL midframe_word %0d: got %h required %h", i, got_a[i], exp_q[i]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        ifa.output_fifo_ready = 1'b1;
        set_cfg(0, 2'd0, 8'd0);
        set_cfg(1, 2'd0, 8'd0);
        test_reset();
        test_flat();
        test_step();
        test_binary();
        test_random_stall();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
